// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file port arbiters: register indices,
// byte-enable encodings and the arbiter state type.
package regfile_pkg;

    localparam logic [3:0] REG_BC = 4'd0;
    localparam logic [3:0] REG_DE = 4'd1;
    localparam logic [3:0] REG_HL = 4'd2;
    localparam logic [3:0] REG_SP = 4'd3;
    localparam logic [3:0] REG_PC = 4'd4;
    localparam logic [3:0] REG_AF = 4'd5;
    localparam logic [3:0] REG_IX = 4'd6;
    localparam logic [3:0] REG_IY = 4'd7;

    localparam logic [1:0] EN_NONE = 2'b00;
    localparam logic [1:0] EN_LO   = 2'b01;
    localparam logic [1:0] EN_HI   = 2'b10;
    localparam logic [1:0] EN_WORD = 2'b11;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester-side bus of the register-file write arbiter: NREQ packed request
// channels with a valid/ready handshake and an ownership lock.
interface regfile_wr_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int REG_W  = 4,
    parameter int DATA_W = 16,
    parameter int FLAG_W = 8
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        req_lock;
    logic [NREQ*REG_W-1:0]  req_reg;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ*2-1:0]      req_en;
    logic [NREQ-1:0]        req_flag_valid;
    logic [NREQ*FLAG_W-1:0] req_flag_data;

    modport master (
        output req_valid, req_lock, req_reg, req_data, req_en,
               req_flag_valid, req_flag_data,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_lock, req_reg, req_data, req_en,
               req_flag_valid, req_flag_data,
        output req_ready
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of req_i strictly after
// ptr_i, wrapping modulo NREQ; returns one-hot grant and its index.
module rr_picker #(
    parameter int NREQ  = 3,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        // offset NREQ wraps back to ptr itself, so it has lowest priority
        for (int off = 1; off <= NREQ; off++) begin
            cand = IDX_W'((int'(ptr_i) + off) % NREQ);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between
// NREQ requesters, with an ownership lock guarded by a watchdog.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int REG_W    = 4,
    parameter int DATA_W   = 16,
    parameter int FLAG_W   = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_wr_arbiter_if.slave     req,
    output logic                    writeReg,
    output logic [1:0]              writeEn,
    output logic [REG_W-1:0]        wrReg,
    output logic [DATA_W-1:0]       wrData,
    output logic                    writeFlag,
    output logic [FLAG_W-1:0]       flagData,
    output logic                    locked,
    output logic [$clog2(NREQ)-1:0] lock_owner,
    output logic                    lock_timeout
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic              wr_q;
    logic [1:0]        wen_q;
    logic [REG_W-1:0]  wreg_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wflag_q;
    logic [FLAG_W-1:0] fdata_q;

    logic [NREQ-1:0]  mask;
    logic [NREQ-1:0]  gnt;
    logic [IDX_W-1:0] gidx;
    logic             gany;
    logic             xfer;

    logic [REG_W-1:0]  reg_a  [NREQ];
    logic [DATA_W-1:0] data_a [NREQ];
    logic [1:0]        en_a   [NREQ];
    logic [FLAG_W-1:0] fd_a   [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign reg_a[i]  = req.req_reg[i*REG_W +: REG_W];
        assign data_a[i] = req.req_data[i*DATA_W +: DATA_W];
        assign en_a[i]   = req.req_en[i*2 +: 2];
        assign fd_a[i]   = req.req_flag_data[i*FLAG_W +: FLAG_W];
    end

    // While locked only the owner's valid reaches the picker.
    always_comb begin
        mask = req.req_valid;
        if (state_q == ARB_LOCKED) begin
            mask = req.req_valid & (NREQ'(1) << owner_q);
        end
    end

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i (mask),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gidx),
        .any_o (gany)
    );

    // No handshake completes while reset is held, so nothing is lost.
    assign req.req_ready = rst ? gnt : '0;
    assign xfer          = gany & rst;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (xfer) begin
                    ptr_d = gidx;
                    if (req.req_lock[gidx]) begin
                        state_d = ARB_LOCKED;
                        owner_d = gidx;
                        cnt_d   = '0;
                    end
                end
            end
            ARB_LOCKED: begin
                if (xfer) begin
                    ptr_d = gidx;
                    cnt_d = '0;
                    if (!req.req_lock[gidx]) begin
                        state_d = ARB_IDLE;
                        owner_d = '0;
                    end
                end else if (!req.req_valid[owner_q] && !req.req_lock[owner_q]) begin
                    state_d = ARB_IDLE;
                    owner_d = '0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_MAX - 1)) begin
                    state_d   = ARB_IDLE;
                    owner_d   = '0;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    ptr_d     = owner_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= IDX_W'(NREQ - 1);
            owner_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            wr_q      <= 1'b0;
            wen_q     <= EN_NONE;
            wreg_q    <= '0;
            wdata_q   <= '0;
            wflag_q   <= 1'b0;
            fdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            wr_q      <= xfer && (en_a[gidx] != EN_NONE);
            wen_q     <= xfer ? en_a[gidx] : EN_NONE;
            wflag_q   <= xfer && req.req_flag_valid[gidx];
            if (xfer) begin
                wreg_q  <= reg_a[gidx];
                wdata_q <= data_a[gidx];
                fdata_q <= fd_a[gidx];
            end
        end
    end

    assign writeReg     = wr_q;
    assign writeEn      = wen_q;
    assign wrReg        = wreg_q;
    assign wrData       = wdata_q;
    assign writeFlag    = wflag_q;
    assign flagData     = fdata_q;
    assign locked       = (state_q == ARB_LOCKED);
    assign lock_owner   = owner_q;
    assign lock_timeout = timeout_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios then random traffic, all
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_regfile_wr_arbiter;
    import regfile_pkg::*;

    localparam int NREQ     = 3;
    localparam int REG_W    = 4;
    localparam int DATA_W   = 16;
    localparam int FLAG_W   = 8;
    localparam int LOCK_MAX = 16;
    localparam int IDX_W    = $clog2(NREQ);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.NREQ(NREQ), .REG_W(REG_W), .DATA_W(DATA_W), .FLAG_W(FLAG_W)) bus ();

    logic              writeReg;
    logic [1:0]        writeEn;
    logic [REG_W-1:0]  wrReg;
    logic [DATA_W-1:0] wrData;
    logic              writeFlag;
    logic [FLAG_W-1:0] flagData;
    logic              locked;
    logic [IDX_W-1:0]  lock_owner;
    logic              lock_timeout;

    regfile_wr_arbiter #(
        .NREQ(NREQ), .REG_W(REG_W), .DATA_W(DATA_W), .FLAG_W(FLAG_W), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (bus),
        .writeReg     (writeReg),
        .writeEn      (writeEn),
        .wrReg        (wrReg),
        .wrData       (wrData),
        .writeFlag    (writeFlag),
        .flagData     (flagData),
        .locked       (locked),
        .lock_owner   (lock_owner),
        .lock_timeout (lock_timeout)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: lock ownership, last-granted requester, idle cycles since the owner's last transfer.
    bit   m_locked = 1'b0;
    int   m_owner  = 0;
    int   m_ptr    = NREQ - 1;
    int   m_since  = 0;
    logic              e_wreg = 1'b0, e_wflag = 1'b0, e_tout = 1'b0;
    logic [1:0]        e_wen = '0;
    logic [REG_W-1:0]  e_wrreg = '0;
    logic [DATA_W-1:0] e_wrdata = '0;
    logic [FLAG_W-1:0] e_fdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0; bus.req_lock = '0; bus.req_reg = '0; bus.req_data = '0;
        bus.req_en = '0; bus.req_flag_valid = '0; bus.req_flag_data = '0;
    endtask

    task automatic set_req(input int i, input bit v, input bit lk, input logic [REG_W-1:0] r,
                           input logic [DATA_W-1:0] d, input logic [1:0] en,
                           input bit fv, input logic [FLAG_W-1:0] fd);
        bus.req_valid[i]                 = v;
        bus.req_lock[i]                  = lk;
        bus.req_reg[i*REG_W +: REG_W]    = r;
        bus.req_data[i*DATA_W +: DATA_W] = d;
        bus.req_en[i*2 +: 2]             = en;
        bus.req_flag_valid[i]            = fv;
        bus.req_flag_data[i*FLAG_W +: FLAG_W] = fd;
    endtask

    task automatic model_grant(output int g);
        g = -1;
        if (rst) begin
            if (m_locked) begin
                if (bus.req_valid[m_owner]) g = m_owner;
            end else begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (g < 0 && bus.req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
                end
            end
        end
    endtask

    task automatic model_step(input int g);
        if (!rst) begin
            m_locked = 1'b0; m_owner = 0; m_ptr = NREQ - 1; m_since = 0;
            e_wreg = 1'b0; e_wen = '0; e_wrreg = '0; e_wrdata = '0;
            e_wflag = 1'b0; e_fdata = '0; e_tout = 1'b0;
        end else begin
            e_tout = 1'b0; e_wreg = 1'b0; e_wen = '0; e_wflag = 1'b0;
            if (g >= 0) begin
                e_wen    = bus.req_en[g*2 +: 2];
                e_wreg   = (e_wen != 2'b00);
                e_wrreg  = bus.req_reg[g*REG_W +: REG_W];
                e_wrdata = bus.req_data[g*DATA_W +: DATA_W];
                e_wflag  = bus.req_flag_valid[g];
                e_fdata  = bus.req_flag_data[g*FLAG_W +: FLAG_W];
                m_ptr    = g;
                if (bus.req_lock[g]) begin
                    m_locked = 1'b1; m_owner = g; m_since = 0;
                end else begin
                    m_locked = 1'b0; m_owner = 0;
                end
            end else if (m_locked) begin
                if (!bus.req_valid[m_owner] && !bus.req_lock[m_owner]) begin
                    m_locked = 1'b0; m_owner = 0;
                end else begin
                    m_since++;
                    if (m_since == LOCK_MAX) begin
                        m_locked = 1'b0; e_tout = 1'b1; m_ptr = m_owner; m_owner = 0;
                    end
                end
            end
        end
    endtask

    // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
    task automatic cycle();
        int g;
        logic [NREQ-1:0] exp_rdy;
        #1;
        model_grant(g);
        exp_rdy = '0;
        if (g >= 0) exp_rdy = NREQ'(1) << g;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        @(posedge clk);
        model_step(g);
        #1;
        chk("writeReg", 32'(writeReg), 32'(e_wreg));
        chk("writeEn", 32'(writeEn), 32'(e_wen));
        chk("wrReg", 32'(wrReg), 32'(e_wrreg));
        chk("wrData", 32'(wrData), 32'(e_wrdata));
        chk("writeFlag", 32'(writeFlag), 32'(e_wflag));
        chk("flagData", 32'(flagData), 32'(e_fdata));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("lock_owner", 32'(lock_owner), 32'(m_owner));
        chk("lock_timeout", 32'(lock_timeout), 32'(e_tout));
    endtask

    initial begin
        logic [DATA_W-1:0] rr_exp [4];
        rr_exp = '{16'h0000, 16'h1100, 16'h2200, 16'h0000};

        // Reset held with every requester valid
        clear_reqs();
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, REG_W'(i), DATA_W'(16'h1100 * i), EN_WORD, 0, '0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) cycle();
        chk("rst_writeReg", 32'(writeReg), 32'd0);
        chk("rst_wrData", 32'(wrData), 32'd0);

        // Round-robin 0,1,2,0,1,2
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("rr_writeReg", 32'(writeReg), 32'd1);
            chk("rr_wrReg", 32'(wrReg), 32'(k % 3));
            if (k < 4) chk("rr_wrData", 32'(wrData), 32'(rr_exp[k]));
        end

        // Byte enables and flags, then a null transfer
        clear_reqs();
        set_req(1, 1, 0, 4'd2, 16'hABCD, EN_LO, 1, 8'hF0);
        cycle();
        chk("be_writeEn", 32'(writeEn), 32'(2'b01));
        chk("be_wrData", 32'(wrData), 32'hABCD);
        chk("be_writeFlag", 32'(writeFlag), 32'd1);
        chk("be_flagData", 32'(flagData), 32'hF0);
        set_req(1, 1, 0, 4'd2, 16'hABCD, EN_NONE, 0, 8'hF0);
        cycle();
        chk("null_writeReg", 32'(writeReg), 32'd0);
        chk("null_writeFlag", 32'(writeFlag), 32'd0);

        // Lock by requester 2 while 0 and 1 compete
        set_req(0, 1, 0, 4'd0, 16'h1111, EN_WORD, 0, '0);
        set_req(1, 1, 0, 4'd1, 16'h2222, EN_WORD, 0, '0);
        set_req(2, 1, 1, 4'd3, 16'h3333, EN_WORD, 0, '0);
        cycle();
        chk("lk_locked", 32'(locked), 32'd1);
        chk("lk_owner", 32'(lock_owner), 32'd2);
        set_req(2, 1, 1, 4'd3, 16'h4444, EN_WORD, 0, '0);
        #1 chk("lk_ready2", 32'(bus.req_ready), 32'(3'b100));
        cycle();
        set_req(2, 1, 0, 4'd3, 16'h5555, EN_WORD, 0, '0);
        #1 chk("lk_ready3", 32'(bus.req_ready), 32'(3'b100));
        cycle();
        chk("lk_released", 32'(locked), 32'd0);
        set_req(2, 0, 0, 4'd3, 16'h5555, EN_WORD, 0, '0);
        #1 chk("lk_next_ready", 32'(bus.req_ready), 32'(3'b001));
        cycle();
        chk("lk_next_data", 32'(wrData), 32'h1111);

        // Watchdog: owner 0 stalls with lock held
        clear_reqs();
        set_req(0, 1, 1, REG_HL, 16'h7777, EN_WORD, 0, '0);
        cycle();
        set_req(0, 0, 1, REG_HL, 16'h7777, EN_WORD, 0, '0);
        set_req(1, 1, 0, REG_DE, 16'h8888, EN_WORD, 0, '0);
        for (int k = 1; k <= LOCK_MAX; k++) begin
            cycle();
            chk("wd_timeout", 32'(lock_timeout), 32'(k == LOCK_MAX));
            chk("wd_locked", 32'(locked), 32'(k != LOCK_MAX));
        end
        #1 chk("wd_next_ready", 32'(bus.req_ready), 32'(3'b010));
        cycle();
        chk("wd_next_data", 32'(wrData), 32'h8888);

        // Reset while locked
        clear_reqs();
        set_req(1, 1, 1, REG_SP, 16'h9999, EN_WORD, 0, '0);
        cycle();
        chk("rl_locked", 32'(locked), 32'd1);
        rst = 1'b0;
        set_req(0, 1, 0, REG_BC, 16'hAAAA, EN_WORD, 0, '0);
        cycle();
        chk("rl_locked0", 32'(locked), 32'd0);
        chk("rl_timeout0", 32'(lock_timeout), 32'd0);
        chk("rl_writeReg0", 32'(writeReg), 32'd0);
        rst = 1'b1;
        #1 chk("rl_ready", 32'(bus.req_ready), 32'(3'b001));
        cycle();
        chk("rl_data", 32'(wrData), 32'hAAAA);

        // Random traffic with periodic stall windows to reach the watchdog
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(63) != 0);
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, $urandom_range(3) != 0, 1'($urandom_range(1)), REG_W'($urandom),
                        DATA_W'($urandom), 2'($urandom), 1'($urandom), FLAG_W'($urandom));
                if ((n % 100) >= 70) begin
                    bus.req_valid[i] = 1'b0;
                    bus.req_lock[i]  = 1'b1;
                end
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port (writeReg / writeEn / wrReg / wrData, plus writeFlag / flagData) between NREQ requesters, e.g. ALU writeback, 16-bit inc/dec unit and load unit.
- Arbitration is round-robin with a valid/ready handshake.
- Supports a lock so one requester can own the port for multi-cycle sequences such as PUSH/POP or 16-bit pair updates. A watchdog forces the lock to release.
- Drives the regfile write inputs directly from registered outputs.

Parameters:
- NREQ, 3, number of requesters (2..8)
- REG_W, 4, register index width (wrReg)
- DATA_W, 16, write data width (hi byte = [15:8], lo byte = [7:0])
- FLAG_W, 8, flag register width
- LOCK_MAX, 16, maximum consecutive cycles a lock may be held before forced release

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  reset; synchronous and active-low (0 = reset)
- req_valid  in  NREQ  request valid per requester
- req_ready  out  NREQ  grant/accept, combinational, one-hot or zero
- req_lock  in  NREQ  requester asks to keep ownership after this transfer
- req_reg  in  NREQ*REG_W  target register index, packed, requester i at [i*REG_W +: REG_W]
- req_data  in  NREQ*DATA_W  write data, packed
- req_en  in  NREQ*2  byte enables; bit1 = hi byte, bit0 = lo byte
- req_flag_valid  in  NREQ  request also writes flags
- req_flag_data  in  NREQ*FLAG_W  flag value, packed
- writeReg  out  1  regfile write strobe
- writeEn  out  2  regfile byte enables
- wrReg  out  REG_W  regfile write index
- wrData  out  DATA_W  regfile write data
- writeFlag  out  1  regfile flag write strobe
- flagData  out  FLAG_W  flag value
- locked  out  1  port is held by lock_owner
- lock_owner  out  $clog2(NREQ)  current owner index; 0 when not locked
- lock_timeout  out  1  one-cycle pulse when the watchdog forces a release

Behaviour:
- Reset (rst=0 at a clock edge):
  - All outputs become 0.
  - State returns to IDLE.
  - Round-robin pointer is set to NREQ-1, so requester 0 has highest priority after reset.
  - Watchdog counter is cleared.
  - Any write registered for the next cycle is dropped.
- IDLE state:
  - Grant goes to the first asserted req_valid found searching from ptr+1 upward, wrapping modulo NREQ.
  - req_ready[g]=1 in the same cycle (combinational); a transfer occurs when valid && ready.
  - On a transfer, ptr <= g.
- Output latency is 1 cycle. On the edge following a transfer:
  - writeReg = |req_en[g]; writeEn = req_en[g]; wrReg and wrData are captured.
  - writeFlag = req_flag_valid[g]; flagData is captured.
  - All strobes are single-cycle and return to 0 when there is no transfer.
  - wrReg, wrData and flagData hold their last value when idle.
- Null transfer: req_en=0 and req_flag_valid=0 is accepted and produces no strobe. It is used to release a lock.
- LOCKED state:
  - Entered when a transfer has req_lock[g]=1. lock_owner <= g, locked <= 1, counter <= 0.
  - Only the owner can be granted; other requesters see req_ready=0.
  - Owner transfer with req_lock=1: remain LOCKED, counter <= 0.
  - Owner transfer with req_lock=0: return to IDLE.
  - Owner with req_valid=0 and req_lock=0: immediate release to IDLE; no write.
  - In any other cycle the counter increments. When the counter reaches LOCK_MAX-1 with no owner transfer, the block forces IDLE, pulses lock_timeout for 1 cycle and sets ptr <= owner.
- Simultaneous requests: exactly one grant per cycle; there is never more than one req_ready high.
- Changing request fields while valid is high and ready is low is legal; the values captured are the ones present in the transfer cycle.
- Reset asserted while LOCKED: lock is cleared, no timeout pulse.

Decomposition:
- Shared package (regfile_pkg) holds:
  - register index constants (REG_BC, REG_DE, REG_HL, REG_SP, REG_PC, REG_AF, ...)
  - byte-enable constants EN_NONE=2'b00, EN_LO=2'b01, EN_HI=2'b10, EN_WORD=2'b11
  - state enum {ARB_IDLE, ARB_LOCKED}
- One sub-module: rr_picker. It is combinational and takes the request mask and pointer, and returns the one-hot grant and its index. It is reusable for the regfile read-port sharing added later.

Test Plan:
- Reset: hold rst=0 for 5 cycles with all req_valid=1 -> all outputs 0. Release -> requester 0 is granted first, and on the next cycle writeReg=1 with wrReg/wrData of requester 0.
- Round-robin: req_valid=3'b111 held, requester i writes reg i, data 16'h1100*i -> grants in the order 0,1,2,0,1,2. wrData sequence is 0000, 1100, 2200, 0000. Exactly one writeReg pulse per cycle.
- Byte enables and flags: requester 1 sends reg 2, data 16'hABCD, en 2'b01, flag_valid=1, flag 8'hF0 -> next cycle writeEn=2'b01, wrData=16'hABCD, writeFlag=1, flagData=8'hF0. Then en=0 with flag_valid=0 -> no writeReg and no writeFlag.
- Lock: requester 2 sends two transfers with req_lock=1 while requesters 0 and 1 are valid -> req_ready[1:0]=0 throughout, locked=1, lock_owner=2. A third transfer with lock=0 -> IDLE, and requester 0 is granted next.
- Watchdog: requester 0 locks, then holds req_valid=0 and req_lock=1 with LOCK_MAX=16 -> lock_timeout pulses 16 cycles after the last transfer, locked=0, and requester 1 is granted next.
- Reset mid-lock: lock requester 1, then rst=0 for 1 cycle -> locked=0, lock_timeout=0, writeReg=0. Requester 0 has priority after release.
